// File: rtl/ravan_dec_feeder.sv
// ravan_dec_feeder: key loader, input pair FIFO, credit-gated issue to the
// free-running RAVAN decryption core, CORE_LAT tag delay line and output FIFO.
// Timing: core_data_in/core_real are registered; the matching core_dout is
// sampled CORE_LAT-1 cycles later and pushed into the output FIFO, giving an
// s_valid to m_valid latency of 2+CORE_LAT cycles when all queues are empty.
module ravan_dec_feeder #(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int CORE_LAT  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_wr,
    input  logic [63:0]  key_word,
    input  logic         key_clear,
    output logic         key_loaded,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [63:0]  s_data,
    input  logic [63:0]  s_ref,
    output logic [511:0] core_key,
    output logic [63:0]  core_data_in,
    output logic [63:0]  core_real,
    input  logic [63:0]  core_dout,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [63:0]  m_data,
    output logic         busy
);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int LW  = $clog2(CORE_LAT + 1);
    localparam int CW  = $clog2(OUT_DEPTH + CORE_LAT + 1) + 1;

    typedef enum logic [1:0] {
        ST_LOAD_KEY = 2'd0,
        ST_RUN      = 2'd1,
        ST_DRAIN    = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     key_cnt_q, key_cnt_d;
    logic [511:0]   core_key_q, core_key_d;
    logic [63:0]    in_data_q [IN_DEPTH];
    logic [63:0]    in_data_d [IN_DEPTH];
    logic [63:0]    in_ref_q [IN_DEPTH];
    logic [63:0]    in_ref_d [IN_DEPTH];
    logic [IAW-1:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [IAW:0]   in_cnt_q, in_cnt_d;
    logic [63:0]    out_mem_q [OUT_DEPTH];
    logic [63:0]    out_mem_d [OUT_DEPTH];
    logic [OAW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [OAW:0]   out_cnt_q, out_cnt_d;
    logic [CORE_LAT-1:0] tag_q, tag_d;
    logic [63:0]    core_data_q, core_data_d, core_real_q, core_real_d;

    logic [LW-1:0]  inflight_s;
    logic [CW-1:0]  credit_sum_s;
    logic           s_ready_s, push_in_s, issue_s, capture_s;
    logic           m_valid_s, pop_out_s, busy_s;

    // Handshake, credit and occupancy decode from the current register state
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < CORE_LAT; i++) begin
            inflight_s = inflight_s + LW'(tag_q[i]);
        end
        credit_sum_s = CW'(out_cnt_q) + CW'(inflight_s);
        s_ready_s    = (state_q == ST_RUN) && (in_cnt_q != (IAW+1)'(IN_DEPTH));
        push_in_s    = s_valid && s_ready_s;
        issue_s      = (state_q != ST_LOAD_KEY) && (in_cnt_q != '0)
                       && (credit_sum_s < CW'(OUT_DEPTH));
        capture_s    = tag_q[CORE_LAT-1];
        m_valid_s    = (out_cnt_q != '0);
        pop_out_s    = m_valid_s && m_ready;
        busy_s       = (in_cnt_q != '0) || (inflight_s != '0) || m_valid_s;
    end

    // Mode FSM next state plus key word assembly and key zeroing on reload
    always_comb begin
        state_d    = state_q;
        key_cnt_d  = key_cnt_q;
        core_key_d = core_key_q;
        case (state_q)
            ST_LOAD_KEY: begin
                if (key_wr) begin
                    core_key_d[{key_cnt_q, 6'd0} +: 64] = key_word;
                    key_cnt_d = key_cnt_q + 3'd1;
                    if (key_cnt_q == 3'd7) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_LOAD_KEY;
                    end
                end else begin
                    state_d = ST_LOAD_KEY;
                end
            end
            ST_RUN: begin
                if (key_clear) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!busy_s && !m_valid_s) begin
                    state_d    = ST_LOAD_KEY;
                    core_key_d = '0;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_LOAD_KEY;
            end
        endcase
    end

    // Input FIFO, issue register and tag delay line next state
    always_comb begin
        in_data_d = in_data_q;
        in_ref_d  = in_ref_q;
        in_wr_d   = in_wr_q;
        in_rd_d   = in_rd_q;
        if (push_in_s) begin
            in_data_d[in_wr_q] = s_data;
            in_ref_d[in_wr_q]  = s_ref;
            in_wr_d            = in_wr_q + IAW'(1);
        end else begin
            in_wr_d = in_wr_q;
        end
        if (issue_s) begin
            in_rd_d     = in_rd_q + IAW'(1);
            core_data_d = in_data_q[in_rd_q];
            core_real_d = in_ref_q[in_rd_q];
        end else begin
            in_rd_d     = in_rd_q;
            core_data_d = 64'd0;
            core_real_d = 64'd0;
        end
        in_cnt_d = in_cnt_q + (IAW+1)'(push_in_s) - (IAW+1)'(issue_s);
        tag_d    = '0;
        tag_d[0] = issue_s;
        for (int i = 1; i < CORE_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Output FIFO next state: capture on tag exit, pop on consumer accept
    always_comb begin
        out_mem_d = out_mem_q;
        out_wr_d  = out_wr_q;
        out_rd_d  = out_rd_q;
        if (capture_s) begin
            out_mem_d[out_wr_q] = core_dout;
            out_wr_d            = out_wr_q + OAW'(1);
        end else begin
            out_wr_d = out_wr_q;
        end
        if (pop_out_s) begin
            out_rd_d = out_rd_q + OAW'(1);
        end else begin
            out_rd_d = out_rd_q;
        end
        out_cnt_d = out_cnt_q + (OAW+1)'(capture_s) - (OAW+1)'(pop_out_s);
    end

    // State registers with synchronous reset discarding all contents
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD_KEY;
            key_cnt_q   <= 3'd0;
            core_key_q  <= '0;
            in_wr_q     <= '0;
            in_rd_q     <= '0;
            in_cnt_q    <= '0;
            out_wr_q    <= '0;
            out_rd_q    <= '0;
            out_cnt_q   <= '0;
            tag_q       <= '0;
            core_data_q <= 64'd0;
            core_real_q <= 64'd0;
            for (int i = 0; i < IN_DEPTH; i++) begin
                in_data_q[i] <= 64'd0;
                in_ref_q[i]  <= 64'd0;
            end
            for (int i = 0; i < OUT_DEPTH; i++) begin
                out_mem_q[i] <= 64'd0;
            end
        end else begin
            state_q     <= state_d;
            key_cnt_q   <= key_cnt_d;
            core_key_q  <= core_key_d;
            in_wr_q     <= in_wr_d;
            in_rd_q     <= in_rd_d;
            in_cnt_q    <= in_cnt_d;
            out_wr_q    <= out_wr_d;
            out_rd_q    <= out_rd_d;
            out_cnt_q   <= out_cnt_d;
            tag_q       <= tag_d;
            core_data_q <= core_data_d;
            core_real_q <= core_real_d;
            in_data_q   <= in_data_d;
            in_ref_q    <= in_ref_d;
            out_mem_q   <= out_mem_d;
        end
    end

    assign key_loaded   = (state_q == ST_RUN);
    assign s_ready      = s_ready_s;
    assign core_key     = core_key_q;
    assign core_data_in = core_data_q;
    assign core_real    = core_real_q;
    assign m_valid      = m_valid_s;
    assign m_data       = out_mem_q[out_rd_q];
    assign busy         = busy_s;
endmodule
